memwb_skid_stage: RTL

Parametrised MEM/WB pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a writeback-forwarding tap. It sits between the memory stage and register-file writeback. It replaces the fixed 32-bit, always-capturing MEM/WB latch with a stallable, flushable stage. It also precomputes the selected writeback value so the hazard unit can forward it.

---
 rtl/memwb_skid_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline register with valid/ready handshake and 2-entry skid.
// Precomputes the writeback value and exposes it as a forwarding tap.
module memwb_skid_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NEG_EDGE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [XLEN-1:0]       load_data_in,
  input  logic [XLEN-1:0]       sum_out_in,
  input  logic [XLEN-1:0]       result_in,
  input  logic [1:0]            control_rf_in,
  input  logic                  we_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       load_data_out,
  output logic [XLEN-1:0]       sum_out_out,
  output logic [XLEN-1:0]       result_out,
  output logic [1:0]            control_rf_out,
  output logic                  we_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [XLEN-1:0]       wb_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd
);

  typedef struct packed {
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       sum_out;
    logic [XLEN-1:0]       result;
    logic [1:0]            ctrl;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  beat_t in_beat;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  accept, drain, main_load;

  assign in_beat = '{
    load_data: load_data_in,
    sum_out:   sum_out_in,
    result:    result_in,
    ctrl:      control_rf_in,
    we:        we_in,
    rd:        rd_in
  };

  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid_q & out_ready;
  assign main_load = !main_valid_q | out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // data may stay stale; only the valid bits matter after a kill
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  if (NEG_EDGE != 0) begin : g_neg
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        main_q       <= '0;
        skid_q       <= '0;
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else begin
        main_q       <= main_d;
        skid_q       <= skid_d;
        main_valid_q <= main_valid_d;
        skid_valid_q <= skid_valid_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_q       <= '0;
        skid_q       <= '0;
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else begin
        main_q       <= main_d;
        skid_q       <= skid_d;
        main_valid_q <= main_valid_d;
        skid_valid_q <= skid_valid_d;
      end
    end
  end

  assign out_valid      = main_valid_q;
  assign load_data_out  = main_q.load_data;
  assign sum_out_out    = main_q.sum_out;
  assign result_out     = main_q.result;
  assign control_rf_out = main_q.ctrl;
  assign rd_out         = main_q.rd;
  assign we_out         = main_valid_q & main_q.we & (main_q.rd != '0);
  assign fwd_valid      = we_out;
  assign fwd_rd         = main_q.rd;

  always_comb begin
    wb_data = main_q.result;
    case (main_q.ctrl)
      2'b01:   wb_data = main_q.load_data;
      2'b10:   wb_data = main_q.sum_out;
      default: wb_data = main_q.result;
    endcase
  end

endmodule
